// File: rtl/end_stats_pkg.sv
// Shared constants, FSM encoding and BCD helper
// for the end-screen statistics capture block.
package end_stats_pkg;

  localparam int unsigned SCORE_W    = 20;
  localparam int unsigned HIT_W      = 7;
  localparam int unsigned BCD_DIGITS = 7;
  localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
  localparam int unsigned CONV_STEPS = 20;
  localparam int unsigned CNT_W      = 5;

  localparam logic [SCORE_W-1:0] SCORE_MAX = 20'd1000000;
  localparam logic [HIT_W-1:0]   HIT_MAX   = 7'd99;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    SHOW = 2'd2
  } state_e;

  // Double-dabble correction: a nibble of 5..9 would
  // overflow past 9 when doubled, so pre-add 3.
  function automatic logic [3:0] dd_adj(
    input logic [3:0] n
  );
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter, one step per clock.
// Ports: clk, resetn, start_i/bin_i load, abort_i, done_o/bcd_o result.
module bin2bcd_seq
  import end_stats_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [SCORE_W-1:0] bin_i,
  output logic               done_o,
  output logic [BCD_W-1:0]   bcd_o
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(CONV_STEPS - 1);

  logic [SCORE_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d, adj;
  logic [CNT_W-1:0]   cnt_q;
  logic               run_q;

  always_comb begin
    adj = '0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      adj[4*i +: 4] = dd_adj(bcd_q[4*i +: 4]);
    end
    bcd_d = {adj[BCD_W-2:0], bin_q[SCORE_W-1]};
    bin_d = {bin_q[SCORE_W-2:0], 1'b0};
  end

  // bcd_o is the post-step value, valid with done_o,
  // so the caller latches it on the final step edge.
  assign done_o = run_q && (cnt_q == LAST);
  assign bcd_o  = bcd_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (abort_i) begin
      run_q <= 1'b0;
    end else if (start_i) begin
      bin_q <= bin_i;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_q + CNT_W'(1);
      if (cnt_q == LAST) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/end_screen_stats_capture.sv
// Snapshots game stats on game_over, converts score to BCD, holds for overlay.
// Ports: clk, resetn, game_over, restart, *_live in; end_mode, busy, latched
// fields and score_d6..d0 out. PERSONAL_BEST_EN adds best_score/new_best.
module end_screen_stats_capture
  import end_stats_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               game_over,
  input  logic               restart,
  input  logic [SCORE_W-1:0] score_live,
  input  logic [HIT_W-1:0]   hit_count_live,
  input  logic               chart_select_live,
  input  logic [1:0]         note_speed_live,
  output logic               end_mode,
  output logic               busy,
  output logic [SCORE_W-1:0] score_value,
  output logic [3:0]         score_d6,
  output logic [3:0]         score_d5,
  output logic [3:0]         score_d4,
  output logic [3:0]         score_d3,
  output logic [3:0]         score_d2,
  output logic [3:0]         score_d1,
  output logic [3:0]         score_d0,
  output logic [HIT_W-1:0]   hit_count,
  output logic               chart_select,
`ifdef PERSONAL_BEST_EN
  output logic [SCORE_W-1:0] best_score,
  output logic               new_best,
`endif
  output logic [1:0]         note_speed
);

  state_e             state_q;
  logic               end_q;
  logic               busy_q;
  logic [SCORE_W-1:0] score_q;
  logic [BCD_W-1:0]   dig_q;
  logic [HIT_W-1:0]   hit_q;
  logic               chart_q;
  logic [1:0]         speed_q;

  logic [SCORE_W-1:0] score_c;
  logic [HIT_W-1:0]   hit_c;
  logic [1:0]         speed_c;
  logic               capture;
  logic               abort;
  logic               conv_done;
  logic [BCD_W-1:0]   conv_bcd;

  always_comb begin
    score_c = (score_live > SCORE_MAX) ?
              SCORE_MAX : score_live;
    hit_c   = (hit_count_live > HIT_MAX) ?
              HIT_MAX : hit_count_live;
    speed_c = (note_speed_live == 2'd0) ?
              2'd1 : note_speed_live;
  end

  // restart outranks game_over in IDLE
  assign capture = (state_q == IDLE) &&
                   game_over && !restart;
  assign abort   = (state_q == CONV) && restart;

  bin2bcd_seq u_conv (
    .clk     (clk),
    .resetn  (resetn),
    .start_i (capture),
    .abort_i (abort),
    .bin_i   (score_c),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

`ifdef PERSONAL_BEST_EN
  logic [SCORE_W-1:0] best_q;
  logic               nb_q;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      end_q   <= 1'b0;
      busy_q  <= 1'b0;
      score_q <= '0;
      dig_q   <= '0;
      hit_q   <= '0;
      chart_q <= 1'b0;
      speed_q <= 2'd1;
`ifdef PERSONAL_BEST_EN
      best_q  <= '0;
      nb_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (capture) begin
            score_q <= score_c;
            hit_q   <= hit_c;
            chart_q <= chart_select_live;
            speed_q <= speed_c;
            busy_q  <= 1'b1;
            state_q <= CONV;
`ifdef PERSONAL_BEST_EN
            nb_q    <= score_c > best_q;
            if (score_c > best_q) begin
              best_q <= score_c;
            end
`endif
          end
        end
        CONV: begin
          if (restart) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
`ifdef PERSONAL_BEST_EN
            nb_q    <= 1'b0;
`endif
          end else if (conv_done) begin
            dig_q   <= conv_bcd;
            busy_q  <= 1'b0;
            end_q   <= 1'b1;
            state_q <= SHOW;
          end
        end
        SHOW: begin
          if (restart) begin
            end_q   <= 1'b0;
            state_q <= IDLE;
`ifdef PERSONAL_BEST_EN
            nb_q    <= 1'b0;
`endif
          end
        end
        default: begin
          end_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign end_mode     = end_q;
  assign busy         = busy_q;
  assign score_value  = score_q;
  assign hit_count    = hit_q;
  assign chart_select = chart_q;
  assign note_speed   = speed_q;
  assign score_d6     = dig_q[27:24];
  assign score_d5     = dig_q[23:20];
  assign score_d4     = dig_q[19:16];
  assign score_d3     = dig_q[15:12];
  assign score_d2     = dig_q[11:8];
  assign score_d1     = dig_q[7:4];
  assign score_d0     = dig_q[3:0];
`ifdef PERSONAL_BEST_EN
  assign best_score   = best_q;
  assign new_best     = nb_q;
`endif

endmodule

// File: tb/tb_end_screen_stats_capture.sv
// Scoreboard bench for end_screen_stats_capture.
// Stimulus pushes expected snapshots; monitor checks on end_mode rise.
module tb_end_screen_stats_capture;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        game_over = 1'b0;
  logic        restart = 1'b0;
  logic [19:0] score_live = '0;
  logic [6:0]  hit_count_live = '0;
  logic        chart_select_live = 1'b0;
  logic [1:0]  note_speed_live = '0;
  logic        end_mode, busy;
  logic [19:0] score_value;
  logic [3:0]  score_d6, score_d5, score_d4, score_d3;
  logic [3:0]  score_d2, score_d1, score_d0;
  logic [6:0]  hit_count;
  logic        chart_select;
  logic [1:0]  note_speed;
`ifdef PERSONAL_BEST_EN
  logic [19:0] best_score;
  logic        new_best;
`endif

  end_screen_stats_capture dut (
    .clk               (clk),
    .resetn            (resetn),
    .game_over         (game_over),
    .restart           (restart),
    .score_live        (score_live),
    .hit_count_live    (hit_count_live),
    .chart_select_live (chart_select_live),
    .note_speed_live   (note_speed_live),
    .end_mode          (end_mode),
    .busy              (busy),
    .score_value       (score_value),
    .score_d6          (score_d6),
    .score_d5          (score_d5),
    .score_d4          (score_d4),
    .score_d3          (score_d3),
    .score_d2          (score_d2),
    .score_d1          (score_d1),
    .score_d0          (score_d0),
    .hit_count         (hit_count),
    .chart_select      (chart_select),
`ifdef PERSONAL_BEST_EN
    .best_score        (best_score),
    .new_best          (new_best),
`endif
    .note_speed        (note_speed)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [19:0] score;
    logic [27:0] dig;
    logic [6:0]  hit;
    logic        chart;
    logic [1:0]  spd;
    logic        nb;
    logic [19:0] best;
    int          cap;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;
  logic prev_end = 1'b0;

  logic [27:0] digs;
  assign digs = {score_d6, score_d5, score_d4, score_d3,
                 score_d2, score_d1, score_d0};

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic void push(
    input logic [19:0] s, input logic [27:0] d,
    input logic [6:0] h, input logic c,
    input logic [1:0] sp, input logic nb,
    input logic [19:0] best);
    exp_t e;
    e.score = s; e.dig = d; e.hit = h;
    e.chart = c; e.spd = sp; e.nb = nb;
    e.best = best; e.cap = cyc;
    sbq.push_back(e);
  endfunction

  // Monitor: every end_mode rise must match a queued snapshot
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (end_mode && !prev_end) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_end_mode at cyc %0d", cyc);
        end else begin
          e = sbq.pop_front();
          chk("score_value", 32'(score_value), 32'(e.score));
          chk("digits", 32'(digs), 32'(e.dig));
          chk("hit_count", 32'(hit_count), 32'(e.hit));
          chk("chart_select", 32'(chart_select), 32'(e.chart));
          chk("note_speed", 32'(note_speed), 32'(e.spd));
          chk("latency", 32'(cyc - e.cap), 32'd20);
`ifdef PERSONAL_BEST_EN
          chk("new_best", 32'(new_best), 32'(e.nb));
          chk("best_score", 32'(best_score), 32'(e.best));
`endif
        end
      end
      prev_end = end_mode;
    end
  end

  task automatic go(input logic [19:0] s, input logic [6:0] h,
                    input logic c, input logic [1:0] sp);
    @(negedge clk);
    score_live = s; hit_count_live = h;
    chart_select_live = c; note_speed_live = sp;
    game_over = 1'b1;
    @(negedge clk);
    game_over = 1'b0;
  endtask

  task automatic wait_end();
    int n = 0;
    while (!end_mode && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!end_mode) begin
      checks++;
      errors++;
      $display("FAIL end_mode_timeout act=0 exp=1");
    end
  endtask

  task automatic do_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic run(input logic [19:0] s, input logic [6:0] h,
                     input logic c, input logic [1:0] sp,
                     input logic [19:0] es, input logic [27:0] ed,
                     input logic [6:0] eh, input logic [1:0] esp,
                     input logic nb, input logic [19:0] best);
    go(s, h, c, sp);
    push(es, ed, eh, c, esp, nb, best);
    wait_end();
    do_restart();
    chk("end_mode_after_restart", 32'(end_mode), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_end_mode"}, 32'(end_mode), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_score"}, 32'(score_value), 32'd0);
    chk({tag, "_digits"}, 32'(digs), 32'd0);
    chk({tag, "_hit"}, 32'(hit_count), 32'd0);
    chk({tag, "_chart"}, 32'(chart_select), 32'd0);
    chk({tag, "_speed"}, 32'(note_speed), 32'd1);
`ifdef PERSONAL_BEST_EN
    chk({tag, "_best"}, 32'(best_score), 32'd0);
    chk({tag, "_new_best"}, 32'(new_best), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // clamp: 1048575 -> 1000000, 120 -> 99
    go(20'd1048575, 7'd120, 1'b0, 2'd2);
    push(20'd1000000, 28'h1000000, 7'd99, 1'b0, 2'd2,
         1'b1, 20'd1000000);
    chk("score_at_E0", 32'(score_value), 32'd1000000);
    chk("busy_at_E0", 32'(busy), 32'd1);
    chk("digits_hold_in_conv", 32'(digs), 32'd0);
    wait_end();
    do_restart();
    chk("end_mode_after_restart", 32'(end_mode), 32'd0);

    // digit ordering and busy width
    go(20'd123456, 7'd50, 1'b1, 2'd3);
    push(20'd123456, 28'h0123456, 7'd50, 1'b1, 2'd3,
         1'b0, 20'd1000000);
    chk("digits_prev_in_conv", 32'(digs), 32'h1000000);
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", 32'(n), 32'd20);
    wait_end();

    // game_over in SHOW is ignored
    go(20'd5, 7'd1, 1'b0, 2'd1);
    repeat (3) @(negedge clk);
    chk("show_end_mode", 32'(end_mode), 32'd1);
    chk("show_busy", 32'(busy), 32'd0);
    chk("show_score", 32'(score_value), 32'd123456);
    chk("show_digits", 32'(digs), 32'h0123456);
    chk("show_hit", 32'(hit_count), 32'd50);
    chk("show_chart", 32'(chart_select), 32'd1);
    chk("show_speed", 32'(note_speed), 32'd3);
    do_restart();
    chk("restart_end_mode", 32'(end_mode), 32'd0);
    chk("restart_digits", 32'(digs), 32'h0123456);
    chk("restart_score", 32'(score_value), 32'd123456);
`ifdef PERSONAL_BEST_EN
    chk("restart_new_best", 32'(new_best), 32'd0);
`endif

    // abort mid-conversion
    go(20'd777, 7'd10, 1'b0, 2'd1);
    repeat (9) @(negedge clk);
    do_restart();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_end_mode", 32'(end_mode), 32'd0);
    chk("abort_digits", 32'(digs), 32'h0123456);
    chk("abort_score", 32'(score_value), 32'd777);
    repeat (25) @(negedge clk);
    chk("abort_no_end", 32'(end_mode), 32'd0);
    chk("abort_idle_busy", 32'(busy), 32'd0);

    // async reset mid-conversion
    go(20'd4321, 7'd5, 1'b1, 2'd2);
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1 chk_reset_vals("async");
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // restart beats game_over in IDLE
    @(negedge clk);
    score_live = 20'd999;
    game_over = 1'b1;
    restart = 1'b1;
    @(negedge clk);
    game_over = 1'b0;
    restart = 1'b0;
    chk("prio_busy", 32'(busy), 32'd0);
    chk("prio_score", 32'(score_value), 32'd0);

    // zero score, speed 0 -> 1
    run(20'd0, 7'd7, 1'b0, 2'd0,
        20'd0, 28'h0, 7'd7, 2'd1, 1'b0, 20'd0);
    // just below ceiling, hit exactly at its ceiling
    run(20'd999999, 7'd99, 1'b1, 2'd1,
        20'd999999, 28'h0999999, 7'd99, 2'd1, 1'b1, 20'd999999);
    // one above ceiling
    run(20'd1000001, 7'd100, 1'b0, 2'd3,
        20'd1000000, 28'h1000000, 7'd99, 2'd3, 1'b1, 20'd1000000);

    // personal best sequence from a fresh reset
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    run(20'd800000, 7'd80, 1'b0, 2'd2,
        20'd800000, 28'h0800000, 7'd80, 2'd2, 1'b1, 20'd800000);
    run(20'd750000, 7'd75, 1'b1, 2'd2,
        20'd750000, 28'h0750000, 7'd75, 2'd2, 1'b0, 20'd800000);
    run(20'd900000, 7'd90, 1'b0, 2'd3,
        20'd900000, 28'h0900000, 7'd90, 2'd3, 1'b1, 20'd900000);
`ifdef PERSONAL_BEST_EN
    chk("best_survives_restart", 32'(best_score), 32'd900000);
`endif

    repeat (5) @(negedge clk);
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/end_screen_stats_capture.md
Name: end_screen_stats_capture

Overview:
- Sits directly upstream of the end-screen text overlay.
- On the game-over event it snapshots the live score, hit count, chart and speed, then runs a 20-cycle iterative binary-to-BCD conversion of the score.
- It then asserts end_mode and holds every field stable for the overlay until the player restarts.

Parameters:
- SCORE_W, 20, width of the score input.
- SCORE_MAX, 1000000, clamp ceiling for the score.
- BCD_DIGITS, 7, number of score decimal digits produced.
- HIT_W, 7, width of the hit count.
- HIT_MAX, 99, clamp ceiling for the hit count.

Ports:
- clk  in  1  system clock (50 MHz).
- resetn  in  1  asynchronous active-low reset.
- game_over  in  1  single-cycle pulse: chart finished.
- restart  in  1  single-cycle pulse: leave end screen.
- score_live  in  20  running raw score.
- hit_count_live  in  7  running hit count.
- chart_select_live  in  1  0 = chart 1, 1 = chart 2.
- note_speed_live  in  2  speed setting 1..3.
- end_mode  out  1  high while the end screen is shown.
- busy  out  1  high during conversion.
- score_value  out  20  latched, clamped score.
- score_d6..score_d0  out  4 each  BCD digits, d6 = most significant.
- hit_count  out  7  latched, clamped hit count.
- chart_select  out  1  latched chart.
- note_speed  out  2  latched speed.

Behaviour:
- Reset: async on resetn low.
  - State goes to IDLE.
  - All outputs read 0, except note_speed, which reads 2'd1.
- FSM has three states: IDLE, CONV, SHOW.
  - end_mode = (state == SHOW).
  - busy = (state == CONV).
- IDLE:
  - On a clock edge with game_over = 1 and restart = 0 (capture edge E0): latch all *_live inputs and go to CONV with step counter = 0.
  - score is latched as min(score_live, SCORE_MAX).
  - hit count is latched as min(hit_count_live, HIT_MAX).
  - note_speed_live = 0 is latched as 1.
- CONV:
  - One double-dabble step per cycle: add 3 to each 4-bit BCD nibble >= 5, then shift {bcd, bin} left by 1.
  - 20 steps occupy edges E1..E20.
  - At E20: load score_d6..d0 from the final BCD register and go to SHOW.
  - end_mode is therefore high from E20, 20 cycles after capture.
  - score_value, hit_count, chart_select and note_speed update at E0.
  - The digit outputs keep their previous values until E20.
- SHOW: all outputs are held constant. restart = 1 causes SHOW -> IDLE, and end_mode falls at that edge.
- Latched data and digits retain their values in IDLE; they are only overwritten by the next capture.
- game_over while in CONV or SHOW is ignored.
- restart while in CONV aborts to IDLE: digits are not updated and end_mode never rises.
- restart and game_over in the same IDLE cycle: restart wins, no capture.
- resetn low mid-CONV: immediate return to the reset state; no partial digits are ever exposed.
- Arithmetic: all comparisons are unsigned. The BCD register is 28 bits. The step counter is 5 bits and counts 0..19.

Optional Feature:
- Macro: PERSONAL_BEST_EN.
- When defined:
  - Adds outputs best_score [19:0] and new_best [0:0].
  - At E0, if the clamped score > best_score, best_score is updated and new_best is set.
  - new_best holds through SHOW and clears on the transition to IDLE.
  - best_score resets to 0 and survives restart.
- When undefined: neither port nor register exists, and all other behaviour is identical.

Decomposition:
- Package end_stats_pkg holds:
  - SCORE_MAX, HIT_MAX, BCD_DIGITS, CONV_STEPS = 20.
  - The state encoding IDLE = 2'd0, CONV = 2'd1, SHOW = 2'd2.
- Sub-module bin2bcd_seq handles the conversion.
  - Ports: start / bin in; done / bcd out; abort input.
  - It owns the shift register and step counter.
  - The top level owns the FSM, capture registers and clamps.

Test Plan:
- Capture and clamp: score_live = 1048575, hit_count_live = 120, game_over pulse -> score_value = 1000000, digits 1,0,0,0,0,0,0, hit_count = 99, end_mode rises exactly 20 cycles after the capture edge.
- Digit ordering: score_live = 123456, chart_select_live = 1, note_speed_live = 3 -> digits 0,1,2,3,4,5,6, chart_select = 1, note_speed = 3, busy high for exactly 20 cycles.
- Restart and input isolation: in SHOW, drive a second game_over with score_live = 5 -> outputs unchanged. restart -> end_mode = 0 on the next edge, digits still 0,1,2,3,4,5,6.
- Abort mid-conversion: restart at step 10 of CONV -> state IDLE, end_mode never asserts, digits keep prior values. Async resetn low mid-CONV -> all outputs are 0 except note_speed = 1.
- Priority in IDLE: game_over and restart in the same cycle -> no capture. score_live = 0 and note_speed_live = 0 -> digits all 0, note_speed = 1.
- PERSONAL_BEST_EN: run scores 800000, then 750000, then 900000 -> new_best = 1, 0, 1 respectively, and best_score = 900000.
